// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and register address type
package regfile_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int NUM_REGS_DEFAULT = 32;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    typedef logic [$clog2(NUM_REGS_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits with RAW/WAW hazard flags
// Ports:
//   clk, rst (async active-low)
//   rs_addr/rs_busy      per-read-port source address and busy flag
//   issue_en/issue_rd    issue request and its destination; issue_ok grants it
//   rd_wr_en/rd          writeback that retires a pending producer
//   flush                clears every pending bit
//   pending_cnt          number of pending bits currently set
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS     = NUM_REGS_DEFAULT,
    parameter int NUM_RD_PORTS = 2,
    localparam int AW          = addr_w(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD_PORTS*AW-1:0] rs_addr,
    output logic [NUM_RD_PORTS-1:0]    rs_busy,
    input  logic                       issue_en,
    input  logic [AW-1:0]              issue_rd,
    output logic                       issue_ok,
    input  logic                       rd_wr_en,
    input  logic [AW-1:0]              rd,
    input  logic                       flush,
    output logic [AW:0]                pending_cnt
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                set_v;
    logic                dec;

    // A same-cycle writeback to a register resolves its pending bit early.
    always_comb begin
        rs_busy = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++)
            rs_busy[i] = pending[rs_addr[i*AW +: AW]] & ~(rd_wr_en && rd == rs_addr[i*AW +: AW]);
    end

    assign issue_ok = issue_en & ~(pending[issue_rd] & ~(rd_wr_en && rd == issue_rd));
    assign set_v    = issue_ok && issue_rd != '0;
    // A granted set always lands on an effectively clear bit, so it always counts up.
    assign dec      = rd_wr_en && pending[rd];

    always_comb begin
        pending_nxt = pending;
        if (rd_wr_en)
            pending_nxt[rd] = 1'b0;
        if (set_v)
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else if (flush) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= pending_cnt + {{AW{1'b0}}, set_v} - {{AW{1'b0}}, dec};
        end
    end

    a_cnt_matches : assert property (@(posedge clk) disable iff (!rst)
        pending_cnt == (AW+1)'($countones(pending)));

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with bypassed registered reads and write scoreboard
// Ports:
//   clk, rst (async active-low)
//   rs_rd_en/rs_addr/rs_rd_data   N registered read ports, x0 reads zero
//   rs_busy                       per-port pending-write hazard
//   issue_en/issue_rd/issue_ok    issue handshake with WAW stall
//   rd_wr_en/rd/rd_wr_data        writeback port, x0 writes dropped
//   flush/pending_cnt             scoreboard flush and occupancy
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int NUM_REGS     = NUM_REGS_DEFAULT,
    parameter int NUM_RD_PORTS = 2,
    parameter int RESET_ZERO   = 1,
    localparam int AW          = addr_w(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rs_rd_en,
    input  logic [NUM_RD_PORTS*AW-1:0]   rs_addr,
    output logic [NUM_RD_PORTS*XLEN-1:0] rs_rd_data,
    output logic [NUM_RD_PORTS-1:0]      rs_busy,
    input  logic                         issue_en,
    input  logic [AW-1:0]                issue_rd,
    output logic                         issue_ok,
    input  logic                         rd_wr_en,
    input  logic [AW-1:0]                rd,
    input  logic [XLEN-1:0]              rd_wr_data,
    input  logic                         flush,
    output logic [AW:0]                  pending_cnt
);

    logic [XLEN-1:0]              mem [NUM_REGS];
    logic [NUM_RD_PORTS*XLEN-1:0] rd_next;
    logic                         wr_ok;

    assign wr_ok = rd_wr_en && rd != '0;

    generate
        if (RESET_ZERO != 0) begin : g_rst_array
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < NUM_REGS; i++)
                        mem[i] <= '0;
                end else if (wr_ok) begin
                    mem[rd] <= rd_wr_data;
                end
            end
        end else begin : g_raw_array
            // Unreset storage; writes are still blocked while reset is held.
            always_ff @(posedge clk) begin
                if (rst && wr_ok)
                    mem[rd] <= rd_wr_data;
            end
        end
    endgenerate

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++)
            rd_next[i*XLEN +: XLEN] = (rs_addr[i*AW +: AW] == '0) ? '0 :
                                      (wr_ok && rd == rs_addr[i*AW +: AW]) ? rd_wr_data :
                                      mem[rs_addr[i*AW +: AW]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rs_rd_data <= '0;
        else if (rs_rd_en)
            rs_rd_data <= rd_next;
    end

    regfile_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_RD_PORTS (NUM_RD_PORTS)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rs_busy     (rs_busy),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_ok    (issue_ok),
        .rd_wr_en    (rd_wr_en),
        .rd          (rd),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of read/bypass, x0, scoreboard hazards, flush and reset
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        rs_rd_en;
    logic [9:0]  rs_addr;
    logic [63:0] rs_rd_data;
    logic [1:0]  rs_busy;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        issue_ok;
    logic        rd_wr_en;
    logic [4:0]  rd;
    logic [31:0] rd_wr_data;
    logic        flush;
    logic [5:0]  pending_cnt;

    int tests;
    int fails;

    regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rs_rd_en    (rs_rd_en),
        .rs_addr     (rs_addr),
        .rs_rd_data  (rs_rd_data),
        .rs_busy     (rs_busy),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_ok    (issue_ok),
        .rd_wr_en    (rd_wr_en),
        .rd          (rd),
        .rd_wr_data  (rd_wr_data),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rs_rd_en = 1'b0; rs_addr = '0; issue_en = 1'b0; issue_rd = '0;
        rd_wr_en = 1'b0; rd = '0; rd_wr_data = '0; flush = 1'b0;
        tick();
        tick();
        tests++;
        if (rs_rd_data !== 64'h0) begin fails++; $display("FAIL reset_data: got %h expected %h", rs_rd_data, 64'h0); end
        tests++;
        if (pending_cnt !== 6'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt); end
        rst = 1'b1;
        rs_rd_en = 1'b1; rs_addr = {5'd0, 5'd5};
        tick();
        tests++;
        if (rs_rd_data !== 64'h0) begin fails++; $display("FAIL first_read: got %h expected %h", rs_rd_data, 64'h0); end
        tests++;
        if (rs_busy !== 2'b00 || pending_cnt !== 6'd0) begin fails++; $display("FAIL first_busy: busy %b cnt %0d expected 00 0", rs_busy, pending_cnt); end
    endtask

    task automatic test_write_bypass();
        rd_wr_en = 1'b1; rd = 5'd5; rd_wr_data = 32'hDEADBEEF; rs_addr = {5'd0, 5'd5};
        tick();
        tests++;
        if (rs_rd_data !== {32'h0, 32'hDEADBEEF}) begin fails++; $display("FAIL bypass: got %h expected %h", rs_rd_data, {32'h0, 32'hDEADBEEF}); end
        rd = 5'd0; rd_wr_data = 32'h1234; rs_addr = {5'd0, 5'd0};
        tick();
        tests++;
        if (rs_rd_data !== 64'h0) begin fails++; $display("FAIL x0_bypass: got %h expected 0", rs_rd_data); end
        rd_wr_en = 1'b0; rs_addr = {5'd0, 5'd5};
        tick();
        tests++;
        if (rs_rd_data !== {32'h0, 32'hDEADBEEF}) begin fails++; $display("FAIL array_read: got %h expected %h", rs_rd_data, {32'h0, 32'hDEADBEEF}); end
    endtask

    task automatic test_raw();
        issue_en = 1'b1; issue_rd = 5'd7;
        #1;
        tests++;
        if (issue_ok !== 1'b1) begin fails++; $display("FAIL raw_issue_ok: got %b expected 1", issue_ok); end
        tick();
        issue_en = 1'b0;
        tests++;
        if (pending_cnt !== 6'd1) begin fails++; $display("FAIL raw_cnt: got %0d expected 1", pending_cnt); end
        rs_addr = {5'd7, 5'd5};
        #1;
        tests++;
        if (rs_busy !== 2'b10) begin fails++; $display("FAIL raw_busy: got %b expected 10", rs_busy); end
        rd_wr_en = 1'b1; rd = 5'd7; rd_wr_data = 32'h55;
        #1;
        tests++;
        if (rs_busy !== 2'b00) begin fails++; $display("FAIL raw_busy_resolved: got %b expected 00", rs_busy); end
        tick();
        rd_wr_en = 1'b0;
        tests++;
        if (rs_rd_data !== {32'h55, 32'hDEADBEEF}) begin fails++; $display("FAIL raw_capture: got %h expected %h", rs_rd_data, {32'h55, 32'hDEADBEEF}); end
        tests++;
        if (pending_cnt !== 6'd0) begin fails++; $display("FAIL raw_cnt_after: got %0d expected 0", pending_cnt); end
    endtask

    task automatic test_waw();
        issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        #1;
        tests++;
        if (issue_ok !== 1'b0) begin fails++; $display("FAIL waw_stall: got %b expected 0", issue_ok); end
        rd_wr_en = 1'b1; rd = 5'd3; rd_wr_data = 32'h33;
        #1;
        tests++;
        if (issue_ok !== 1'b1) begin fails++; $display("FAIL waw_resolve: got %b expected 1", issue_ok); end
        tick();
        issue_en = 1'b0; rd_wr_en = 1'b0; rs_addr = {5'd0, 5'd3};
        #1;
        tests++;
        if (pending_cnt !== 6'd1 || rs_busy !== 2'b01) begin fails++; $display("FAIL waw_replace: cnt %0d busy %b expected 1 01", pending_cnt, rs_busy); end
        rd_wr_en = 1'b1; rd = 5'd3; rd_wr_data = 32'h34;
        tick();
        rd_wr_en = 1'b0;
        tests++;
        if (pending_cnt !== 6'd0) begin fails++; $display("FAIL waw_clear: got %0d expected 0", pending_cnt); end
        issue_en = 1'b1; issue_rd = 5'd0;
        #1;
        tests++;
        if (issue_ok !== 1'b1) begin fails++; $display("FAIL x0_issue_ok: got %b expected 1", issue_ok); end
        tick();
        issue_en = 1'b0;
        tests++;
        if (pending_cnt !== 6'd0) begin fails++; $display("FAIL x0_no_pending: got %0d expected 0", pending_cnt); end
    endtask

    task automatic test_flush();
        issue_en = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            issue_rd = 5'(r);
            tick();
        end
        tests++;
        if (pending_cnt !== 6'd4) begin fails++; $display("FAIL flush_pre_cnt: got %0d expected 4", pending_cnt); end
        issue_rd = 5'd9; flush = 1'b1;
        tick();
        issue_en = 1'b0; flush = 1'b0; rs_addr = {5'd9, 5'd1};
        #1;
        tests++;
        if (pending_cnt !== 6'd0 || rs_busy !== 2'b00) begin fails++; $display("FAIL flush: cnt %0d busy %b expected 0 00", pending_cnt, rs_busy); end
        rd_wr_en = 1'b1; rd = 5'd1; rd_wr_data = 32'hAA;
        tick();
        rd_wr_en = 1'b0;
        tests++;
        if (pending_cnt !== 6'd0 || rs_rd_data[31:0] !== 32'hAA) begin fails++; $display("FAIL nonpending_wb: cnt %0d data %h expected 0 000000aa", pending_cnt, rs_rd_data[31:0]); end
    endtask

    task automatic test_hold_reset();
        rs_addr = {5'd0, 5'd6}; rd_wr_en = 1'b1; rd = 5'd6; rd_wr_data = 32'h66;
        tick();
        rs_rd_en = 1'b0; rd_wr_data = 32'h77;
        tick();
        rd_wr_en = 1'b0;
        tick();
        tests++;
        if (rs_rd_data !== {32'h0, 32'h66}) begin fails++; $display("FAIL read_hold: got %h expected %h", rs_rd_data, {32'h0, 32'h66}); end
        rs_rd_en = 1'b1;
        tick();
        tests++;
        if (rs_rd_data !== {32'h0, 32'h77}) begin fails++; $display("FAIL read_resume: got %h expected %h", rs_rd_data, {32'h0, 32'h77}); end
        issue_en = 1'b1; issue_rd = 5'd10;
        tick();
        issue_en = 1'b0;
        rd_wr_en = 1'b1; rd = 5'd6; rd_wr_data = 32'h99;
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (rs_rd_data !== 64'h0 || pending_cnt !== 6'd0) begin fails++; $display("FAIL async_reset: data %h cnt %0d expected 0 0", rs_rd_data, pending_cnt); end
        tick();
        rst = 1'b1; rd_wr_en = 1'b0;
        tick();
        tests++;
        if (rs_rd_data !== 64'h0) begin fails++; $display("FAIL reset_no_commit: got %h expected 0", rs_rd_data); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write_bypass();
        test_raw();
        test_waw();
        test_flush();
        test_hold_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
